// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD bus-cycle engine.
package lcd_pkg;

  // Bus-cycle engine states: busy-flag read, turnaround, write, completion.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_BSETUP,
    ST_BEN,
    ST_BHOLD,
    ST_TURN,
    ST_WSETUP,
    ST_WEN,
    ST_WHOLD,
    ST_DONE
  } lcd_state_e;

  // HD44780 command bytes used by the upstream sequencer.
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;
  localparam logic [7:0] CMD_DISP_ON_CUR  = 8'h0E;
  localparam logic [7:0] CMD_FUNC_8BIT_2L = 8'h38;

  // Busy flag position on the data bus during a status read.
  localparam int BUSY_BIT = 7;

  // Largest of three phase lengths; sizes the shared phase timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; last_o marks the final cycle of the current phase.
module lcd_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q;

  // Reload on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_cycle.sv
// HD44780 8-bit bus-cycle engine: optional busy-flag polling followed by a
// timed write, one byte per valid/ready handshake. All outputs registered.
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int T_AS      = 2,
  parameter int T_EN      = 12,
  parameter int T_H       = 2,
  parameter int MAX_POLLS = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic       req_poll,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic       rsp_timeout,
  output logic       rs_lcd,
  output logic       rw_lcd,
  output logic       en_lcd,
  output logic [7:0] data_lcd_out,
  output logic       data_lcd_oe,
  input  logic [7:0] data_lcd_in
);

  localparam int PH_W = $clog2(max3(T_AS, T_EN, T_H) + 1);
  localparam int PC_W = $clog2(MAX_POLLS + 1);

  localparam logic [PH_W-1:0] LD_AS = PH_W'(T_AS - 1);
  localparam logic [PH_W-1:0] LD_EN = PH_W'(T_EN - 1);
  localparam logic [PH_W-1:0] LD_H  = PH_W'(T_H - 1);

  localparam logic [PC_W-1:0] POLL_LAST = PC_W'(MAX_POLLS - 1);
  localparam logic [PC_W-1:0] POLL_SAT  = PC_W'(MAX_POLLS);

  lcd_state_e      state_q, state_d;
  logic [PC_W-1:0] poll_cnt_q, poll_cnt_d;
  logic            busy_q, busy_d;
  logic            rs_cap_q, rs_cap_d;
  logic [7:0]      data_cap_q, data_cap_d;
  logic            timeout_d;

  logic            tmr_load;
  logic [PH_W-1:0] tmr_val;
  logic            tmr_last;

  logic            req_ready_q, rsp_valid_q, rsp_timeout_q;
  logic            rs_q, rw_q, en_q, oe_q;
  logic [7:0]      data_q;
  logic            wr_d, rd_d;

  // Only the busy flag is meaningful on a status read.
  logic            unused_status;
  assign unused_status = ^{data_lcd_in[BUSY_BIT-1:0]};

  lcd_phase_timer #(
    .W(PH_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .last_o    (tmr_last)
  );

  // Next-state, capture and phase-timer reload decisions.
  always_comb begin
    state_d    = state_q;
    poll_cnt_d = poll_cnt_q;
    busy_d     = busy_q;
    rs_cap_d   = rs_cap_q;
    data_cap_d = data_cap_q;
    timeout_d  = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rs_cap_d   = req_rs;
          data_cap_d = req_data;
          poll_cnt_d = '0;
          state_d    = req_poll ? ST_BSETUP : ST_WSETUP;
          tmr_load   = 1'b1;
          tmr_val    = LD_AS;
        end
      end
      ST_BSETUP: begin
        if (tmr_last) begin
          state_d  = ST_BEN;
          tmr_load = 1'b1;
          tmr_val  = LD_EN;
        end
      end
      ST_BEN: begin
        if (tmr_last) begin
          busy_d   = data_lcd_in[BUSY_BIT];
          state_d  = ST_BHOLD;
          tmr_load = 1'b1;
          tmr_val  = LD_H;
        end
      end
      ST_BHOLD: begin
        if (tmr_last) begin
          if (!busy_q) begin
            state_d = ST_TURN;
          end else if (poll_cnt_q == POLL_LAST) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
          end else begin
            if (poll_cnt_q != POLL_SAT) poll_cnt_d = poll_cnt_q + 1'b1;
            state_d  = ST_BSETUP;
            tmr_load = 1'b1;
            tmr_val  = LD_AS;
          end
        end
      end
      ST_TURN: begin
        state_d  = ST_WSETUP;
        tmr_load = 1'b1;
        tmr_val  = LD_AS;
      end
      ST_WSETUP: begin
        if (tmr_last) begin
          state_d  = ST_WEN;
          tmr_load = 1'b1;
          tmr_val  = LD_EN;
        end
      end
      ST_WEN: begin
        if (tmr_last) begin
          state_d  = ST_WHOLD;
          tmr_load = 1'b1;
          tmr_val  = LD_H;
        end
      end
      ST_WHOLD: begin
        if (tmr_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Phase classification of the upcoming state drives the registered outputs.
  always_comb begin
    wr_d = (state_d == ST_WSETUP) || (state_d == ST_WEN) || (state_d == ST_WHOLD);
    rd_d = (state_d == ST_BSETUP) || (state_d == ST_BEN) || (state_d == ST_BHOLD);
  end

  // State, captured request and registered bus outputs; reset aborts any cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      poll_cnt_q    <= '0;
      busy_q        <= 1'b0;
      rs_cap_q      <= 1'b0;
      data_cap_q    <= 8'h00;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rs_q          <= 1'b0;
      rw_q          <= 1'b0;
      en_q          <= 1'b0;
      oe_q          <= 1'b0;
      data_q        <= 8'h00;
    end else begin
      state_q       <= state_d;
      poll_cnt_q    <= poll_cnt_d;
      busy_q        <= busy_d;
      rs_cap_q      <= rs_cap_d;
      data_cap_q    <= data_cap_d;
      req_ready_q   <= (state_d == ST_IDLE);
      rsp_valid_q   <= (state_d == ST_DONE);
      rsp_timeout_q <= timeout_d;
      rs_q          <= wr_d & rs_cap_d;
      rw_q          <= rd_d;
      en_q          <= (state_d == ST_BEN) || (state_d == ST_WEN);
      oe_q          <= wr_d;
      data_q        <= wr_d ? data_cap_d : 8'h00;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign rs_lcd       = rs_q;
  assign rw_lcd       = rw_q;
  assign en_lcd       = en_q;
  assign data_lcd_oe  = oe_q;
  assign data_lcd_out = data_q;

endmodule

// File: tb/tb_lcd_bus_cycle.sv
// Bench for lcd_bus_cycle: scenario tasks against a timeline reference model.
module tb_lcd_bus_cycle;

  localparam int TB_AS   = 2;
  localparam int TB_EN   = 12;
  localparam int TB_H    = 2;
  localparam int TB_MAXP = 4;
  localparam int PER     = TB_AS + TB_EN + TB_H;

  typedef struct {
    int         start;
    int         len;
    logic       rw;
    logic       oe;
    logic       rs;
    logic [7:0] d;
  } pulse_t;

  typedef struct {
    logic       rs;
    logic       poll;
    logic [7:0] d;
    int         nbusy;
  } req_t;

  logic       clk, rst;
  logic       req_valid, req_ready, req_rs, req_poll;
  logic [7:0] req_data;
  logic       rsp_valid, rsp_timeout;
  logic       rs_lcd, rw_lcd, en_lcd, data_lcd_oe;
  logic [7:0] data_lcd_out, data_lcd_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  req_t   req_q[$];
  req_t   acc_req[$];
  int     acc_k[$];
  pulse_t obs_p[$];
  int     obs_rsp[$];
  logic   obs_to[$];
  pulse_t exp_p[$];
  int     exp_rsp[$];
  logic   exp_to[$];
  int     viol, bad_oe, oe_first;
  logic   ready_after;

  lcd_bus_cycle #(
    .T_AS(TB_AS), .T_EN(TB_EN), .T_H(TB_H), .MAX_POLLS(TB_MAXP)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs(req_rs),
    .req_poll(req_poll), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout),
    .rs_lcd(rs_lcd), .rw_lcd(rw_lcd), .en_lcd(en_lcd),
    .data_lcd_out(data_lcd_out), .data_lcd_oe(data_lcd_oe),
    .data_lcd_in(data_lcd_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Timeline model: for each accepted request at edge k, list the strobes
  // and the response cycle implied by the phase lengths and busy pattern.
  function automatic void build_model();
    exp_p.delete(); exp_rsp.delete(); exp_to.delete();
    foreach (acc_req[j]) begin
      int k, t, nr;
      bit to;
      k = acc_k[j];
      t = k;
      to = 0;
      if (acc_req[j].poll) begin
        nr = (acc_req[j].nbusy + 1 < TB_MAXP) ? acc_req[j].nbusy + 1 : TB_MAXP;
        to = (acc_req[j].nbusy >= TB_MAXP);
        for (int i = 0; i < nr; i++)
          exp_p.push_back('{k + i*PER + TB_AS + 1, TB_EN, 1'b1, 1'b0, 1'b0, 8'h00});
        t = k + nr*PER;
        if (!to) t = t + 1;
      end
      if (to) begin
        exp_rsp.push_back(t + 1);
        exp_to.push_back(1'b1);
      end else begin
        exp_p.push_back('{t + TB_AS + 1, TB_EN, 1'b0, 1'b1, acc_req[j].rs, acc_req[j].d});
        exp_rsp.push_back(t + PER + 1);
        exp_to.push_back(1'b0);
      end
    end
  endfunction

  // Drives queued requests when ready, emulates the LCD busy flag and records
  // strobes, responses and bus-discipline violations until n responses seen.
  task automatic run_txns(input int n, input bit junk);
    int got, L, reads_done, cur_nbusy, last_fall;
    bit presented, fin, prev_en, prev_rw, prev_rs, changed;
    logic [7:0] prev_d;
    obs_p.delete(); obs_rsp.delete(); obs_to.delete();
    acc_req.delete(); acc_k.delete();
    viol = 0; bad_oe = 0; oe_first = -1; ready_after = 1'b0;
    got = 0; reads_done = 0; cur_nbusy = 0; last_fall = -100;
    presented = 0; fin = 0;
    prev_en = en_lcd; prev_rw = rw_lcd; prev_rs = rs_lcd; prev_d = data_lcd_out;
    for (int b = 0; b < 3000; b++) begin
      @(negedge clk);
      L = cyc + 1;
      if (fin) begin
        ready_after = req_ready;
        break;
      end
      if (presented) begin
        acc_req.push_back(req_q[0]);
        acc_k.push_back(cyc);
        cur_nbusy = req_q[0].nbusy;
        void'(req_q.pop_front());
        reads_done = 0;
        presented = 0;
      end
      changed = (rs_lcd !== prev_rs) || (rw_lcd !== prev_rw) || (data_lcd_out !== prev_d);
      if (changed && (en_lcd || prev_en || L < last_fall + TB_H)) viol++;
      if (en_lcd && !prev_en)
        obs_p.push_back('{L, 1, rw_lcd, data_lcd_oe, rs_lcd, data_lcd_out});
      else if (en_lcd && obs_p.size() > 0)
        obs_p[obs_p.size()-1].len++;
      if (!en_lcd && prev_en) begin
        last_fall = L;
        if (prev_rw) reads_done++;
      end
      if (data_lcd_oe && rw_lcd) bad_oe++;
      if (data_lcd_oe && oe_first < 0) oe_first = L;
      if (rsp_valid) begin
        obs_rsp.push_back(L);
        obs_to.push_back(rsp_timeout);
        got++;
        if (got == n) fin = 1;
      end
      prev_en = en_lcd; prev_rw = rw_lcd; prev_rs = rs_lcd; prev_d = data_lcd_out;
      if (req_ready && req_q.size() > 0 && !fin) begin
        req_valid = 1'b1;
        req_rs    = req_q[0].rs;
        req_poll  = req_q[0].poll;
        req_data  = req_q[0].d;
        presented = 1;
      end else if (junk && !req_ready) begin
        req_valid = 1'b1;
        req_rs    = 1'($urandom);
        req_poll  = 1'($urandom);
        req_data  = 8'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      data_lcd_in = {(reads_done < cur_nbusy), 7'($urandom)};
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b exp 1", req_ready);
    end
    checks++;
    if ({rsp_valid, rsp_timeout, rs_lcd, rw_lcd, en_lcd, data_lcd_oe, data_lcd_out} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outs got v=%b t=%b rs=%b rw=%b en=%b oe=%b d=%h exp all 0",
               rsp_valid, rsp_timeout, rs_lcd, rw_lcd, en_lcd, data_lcd_oe, data_lcd_out);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rs_lcd, rw_lcd, en_lcd, data_lcd_oe, data_lcd_out} !== 14'h2000) begin
      errors++;
      $display("FAIL idle_after_release got rdy=%b v=%b en=%b oe=%b d=%h exp rdy=1 others 0",
               req_ready, rsp_valid, en_lcd, data_lcd_oe, data_lcd_out);
    end
  endtask

  task automatic test_plain_write();
    req_q.push_back('{1'b1, 1'b0, 8'h50, 0});
    run_txns(1, 0);
    build_model();
    checks++;
    if (obs_rsp.size() !== 1 || obs_p.size() !== 1) begin
      errors++; $display("FAIL plain_counts got rsp=%0d pulses=%0d exp 1 1", obs_rsp.size(), obs_p.size());
    end else begin
      checks++;
      if (obs_p[0].start !== exp_p[0].start || obs_p[0].len !== TB_EN || obs_p[0].d !== 8'h50 ||
          obs_p[0].rs !== 1'b1 || obs_p[0].rw !== 1'b0 || obs_p[0].oe !== 1'b1) begin
        errors++;
        $display("FAIL plain_pulse got start=%0d len=%0d d=%h rs=%b rw=%b oe=%b exp start=%0d len=%0d d=50 rs=1 rw=0 oe=1",
                 obs_p[0].start, obs_p[0].len, obs_p[0].d, obs_p[0].rs, obs_p[0].rw, obs_p[0].oe,
                 exp_p[0].start, TB_EN);
      end
      checks++;
      if (obs_rsp[0] !== acc_k[0] + 17 || obs_to[0] !== 1'b0) begin
        errors++; $display("FAIL plain_rsp got cyc=%0d to=%b exp cyc=%0d to=0", obs_rsp[0], obs_to[0], acc_k[0] + 17);
      end
    end
    checks++;
    if (acc_k.size() !== 1 || oe_first !== acc_k[0] + 1) begin
      errors++; $display("FAIL plain_oe_first got %0d exp k+1", oe_first);
    end
    checks++;
    if (ready_after !== 1'b1 || viol !== 0) begin
      errors++; $display("FAIL plain_ready_bus got rdy=%b viol=%0d exp 1 0", ready_after, viol);
    end
  endtask

  task automatic test_busy_poll();
    req_q.push_back('{1'b0, 1'b1, 8'h06, 3});
    run_txns(1, 0);
    build_model();
    checks++;
    if (obs_p.size() !== exp_p.size()) begin
      errors++; $display("FAIL poll_npulse got %0d exp %0d", obs_p.size(), exp_p.size());
    end
    for (int i = 0; i < exp_p.size() && i < obs_p.size(); i++) begin
      checks++;
      if (obs_p[i].start !== exp_p[i].start || obs_p[i].len !== exp_p[i].len ||
          obs_p[i].rw !== exp_p[i].rw || obs_p[i].oe !== exp_p[i].oe ||
          (exp_p[i].oe && (obs_p[i].rs !== exp_p[i].rs || obs_p[i].d !== exp_p[i].d))) begin
        errors++;
        $display("FAIL poll_pulse%0d got st=%0d len=%0d rw=%b oe=%b d=%h exp st=%0d len=%0d rw=%b oe=%b d=%h", i,
                 obs_p[i].start, obs_p[i].len, obs_p[i].rw, obs_p[i].oe, obs_p[i].d,
                 exp_p[i].start, exp_p[i].len, exp_p[i].rw, exp_p[i].oe, exp_p[i].d);
      end
    end
    checks++;
    if (obs_rsp.size() !== 1 || obs_rsp[0] !== exp_rsp[0] || obs_to[0] !== 1'b0) begin
      errors++; $display("FAIL poll_rsp got n=%0d exp cyc=%0d to=0", obs_rsp.size(), exp_rsp[0]);
    end
    checks++;
    if (viol !== 0 || bad_oe !== 0 || ready_after !== 1'b1) begin
      errors++; $display("FAIL poll_bus got viol=%0d bad_oe=%0d rdy=%b exp 0 0 1", viol, bad_oe, ready_after);
    end
  endtask

  task automatic test_timeout();
    req_q.push_back('{1'b1, 1'b1, 8'hC3, 1000});
    run_txns(1, 0);
    build_model();
    checks++;
    if (obs_p.size() !== TB_MAXP) begin
      errors++; $display("FAIL timeout_reads got %0d exp %0d", obs_p.size(), TB_MAXP);
    end
    for (int i = 0; i < exp_p.size() && i < obs_p.size(); i++) begin
      checks++;
      if (obs_p[i].start !== exp_p[i].start || obs_p[i].rw !== 1'b1 || obs_p[i].len !== TB_EN) begin
        errors++; $display("FAIL timeout_pulse%0d got st=%0d rw=%b exp st=%0d rw=1", i, obs_p[i].start, obs_p[i].rw, exp_p[i].start);
      end
    end
    checks++;
    if (oe_first !== -1) begin
      errors++; $display("FAIL timeout_oe got first oe cycle %0d exp never", oe_first);
    end
    checks++;
    if (obs_rsp.size() !== 1 || obs_rsp[0] !== exp_rsp[0] || obs_to[0] !== 1'b1) begin
      errors++; $display("FAIL timeout_rsp got n=%0d exp cyc=%0d to=1", obs_rsp.size(), exp_rsp[0]);
    end
  endtask

  task automatic test_reset_midop();
    int seen_rsp, waited;
    logic [7:0] d2;
    @(negedge clk);
    req_valid = 1'b1; req_rs = 1'b1; req_poll = 1'b0; req_data = 8'hA5;
    @(negedge clk);
    req_valid = 1'b0;
    waited = 0;
    while (!en_lcd && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (en_lcd !== 1'b1 || data_lcd_oe !== 1'b1) begin
      errors++; $display("FAIL midop_in_wen got en=%b oe=%b exp 1 1", en_lcd, data_lcd_oe);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (en_lcd !== 1'b0 || data_lcd_oe !== 1'b0) begin
      errors++; $display("FAIL midop_async_drop got en=%b oe=%b exp 0 0", en_lcd, data_lcd_oe);
    end
    seen_rsp = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp++;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp++;
    end
    checks++;
    if (seen_rsp !== 0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL midop_no_rsp got rsp=%0d rdy=%b exp 0 1", seen_rsp, req_ready);
    end
    d2 = 8'($urandom);
    req_q.push_back('{1'b0, 1'b0, d2, 0});
    run_txns(1, 0);
    checks++;
    if (obs_p.size() !== 1 || obs_rsp.size() !== 1 || acc_k.size() !== 1) begin
      errors++; $display("FAIL midop_rewrite_counts got pulses=%0d rsp=%0d exp 1 1", obs_p.size(), obs_rsp.size());
    end else if (obs_p[0].d !== d2 || obs_p[0].start !== acc_k[0] + TB_AS + 1 ||
                 obs_rsp[0] !== acc_k[0] + PER + 1 || obs_to[0] !== 1'b0) begin
      errors++;
      $display("FAIL midop_rewrite got d=%h st=%0d rsp=%0d exp d=%h st=%0d rsp=%0d",
               obs_p[0].d, obs_p[0].start, obs_rsp[0], d2, acc_k[0] + TB_AS + 1, acc_k[0] + PER + 1);
    end
  endtask

  task automatic test_back_to_back();
    req_q.push_back('{1'b1, 1'b0, 8'h3C, 0});
    req_q.push_back('{1'b0, 1'b0, 8'h38, 0});
    run_txns(2, 1);
    build_model();
    checks++;
    if (obs_p.size() !== 2 || obs_rsp.size() !== 2) begin
      errors++; $display("FAIL b2b_counts got pulses=%0d rsp=%0d exp 2 2", obs_p.size(), obs_rsp.size());
    end else begin
      checks++;
      if (obs_p[0].d !== 8'h3C || obs_p[1].d !== 8'h38 || obs_p[0].rs !== 1'b1 || obs_p[1].rs !== 1'b0) begin
        errors++; $display("FAIL b2b_data got %h/%b %h/%b exp 3c/1 38/0", obs_p[0].d, obs_p[0].rs, obs_p[1].d, obs_p[1].rs);
      end
      checks++;
      if (obs_p[1].start - obs_p[0].start !== PER + 2) begin
        errors++; $display("FAIL b2b_spacing got %0d exp %0d", obs_p[1].start - obs_p[0].start, PER + 2);
      end
      checks++;
      if (obs_rsp[0] !== exp_rsp[0] || obs_rsp[1] !== exp_rsp[1]) begin
        errors++; $display("FAIL b2b_rsp got %0d %0d exp %0d %0d", obs_rsp[0], obs_rsp[1], exp_rsp[0], exp_rsp[1]);
      end
    end
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL b2b_bus_stable got viol=%0d exp 0", viol);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      req_q.push_back('{1'($urandom), 1'($urandom), 8'($urandom), int'($urandom_range(0, TB_MAXP + 1))});
    run_txns(6, 1);
    build_model();
    checks++;
    if (obs_p.size() !== exp_p.size() || obs_rsp.size() !== exp_rsp.size()) begin
      errors++; $display("FAIL rand_counts got pulses=%0d rsp=%0d exp %0d %0d",
                         obs_p.size(), obs_rsp.size(), exp_p.size(), exp_rsp.size());
    end
    for (int i = 0; i < exp_p.size() && i < obs_p.size(); i++) begin
      checks++;
      if (obs_p[i].start !== exp_p[i].start || obs_p[i].len !== exp_p[i].len ||
          obs_p[i].rw !== exp_p[i].rw || obs_p[i].oe !== exp_p[i].oe ||
          (exp_p[i].oe && (obs_p[i].rs !== exp_p[i].rs || obs_p[i].d !== exp_p[i].d))) begin
        errors++;
        $display("FAIL rand_pulse%0d got st=%0d len=%0d rw=%b oe=%b d=%h exp st=%0d len=%0d rw=%b oe=%b d=%h", i,
                 obs_p[i].start, obs_p[i].len, obs_p[i].rw, obs_p[i].oe, obs_p[i].d,
                 exp_p[i].start, exp_p[i].len, exp_p[i].rw, exp_p[i].oe, exp_p[i].d);
      end
    end
    for (int i = 0; i < exp_rsp.size() && i < obs_rsp.size(); i++) begin
      checks++;
      if (obs_rsp[i] !== exp_rsp[i] || obs_to[i] !== exp_to[i]) begin
        errors++; $display("FAIL rand_rsp%0d got cyc=%0d to=%b exp cyc=%0d to=%b", i, obs_rsp[i], obs_to[i], exp_rsp[i], exp_to[i]);
      end
    end
    checks++;
    if (viol !== 0 || bad_oe !== 0 || ready_after !== 1'b1) begin
      errors++; $display("FAIL rand_bus got viol=%0d bad_oe=%0d rdy=%b exp 0 0 1", viol, bad_oe, ready_after);
    end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_rs = 1'b0; req_poll = 1'b0; req_data = 8'h00;
    data_lcd_in = 8'h00;
    test_reset();
    test_plain_write();
    test_busy_poll();
    test_timeout();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
